// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shift mode type and bank-sizing helpers for the pipelined barrel shifter
package shifter_pkg;

   typedef enum logic [1:0] {SH_LSL = 2'b00, SH_LSR = 2'b01, SH_ASR = 2'b10, SH_ROR = 2'b11} shift_mode_t;

   function automatic int stages_per_bank(input int n_stages, input int n_banks);
      return (n_stages + n_banks - 1) / n_banks;
   endfunction

   function automatic int bank_last_stage(input int bank, input int spb, input int n_stages);
      return (((bank + 1) * spb < n_stages) ? (bank + 1) * spb : n_stages) - 1;
   endfunction

endpackage

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - one conditional power-of-two shift step; SHIFTER_ROR_EN enables the rotate leg
module shift_stage
   import shifter_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int AMT   = 1
) (
   input  logic [WIDTH-1:0] data_i,
   input  logic             enable_i,
   input  shift_mode_t      mode_i,
   input  logic             sign_i,
   output logic [WIDTH-1:0] data_o
);

   always_comb begin
      data_o = data_i;
      if (enable_i) begin
         case (mode_i)
            SH_LSL:  data_o = {data_i[WIDTH-AMT-1:0], {AMT{1'b0}}};
            SH_ASR:  data_o = {{AMT{sign_i}}, data_i[WIDTH-1:AMT]};
`ifdef SHIFTER_ROR_EN
            SH_ROR:  data_o = {data_i[AMT-1:0], data_i[WIDTH-1:AMT]};
`endif
            default: data_o = {{AMT{1'b0}}, data_i[WIDTH-1:AMT]};
         endcase
      end
   end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// rtl/pipelined_barrel_shifter.sv - LSL/LSR/ASR(/ROR with SHIFTER_ROR_EN) shifter split over PIPE valid/ready banks
module pipelined_barrel_shifter
   import shifter_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int PIPE  = 2,
   parameter int TAG_W = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   input  logic [$clog2(WIDTH)-1:0] in_shamt,
   input  shift_mode_t              in_mode,
   input  logic [TAG_W-1:0]         in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [TAG_W-1:0]         out_tag
);

   localparam int SW  = $clog2(WIDTH);
   localparam int SPB = stages_per_bank(SW, PIPE);

   logic [PIPE-1:0]  valid_q;
   logic [PIPE-1:0]  adv;
   logic [WIDTH-1:0] data_q   [PIPE];
   logic [SW-1:0]    shamt_q  [PIPE];
   shift_mode_t      mode_q   [PIPE];
   logic             sign_q   [PIPE];
   logic [TAG_W-1:0] tag_q    [PIPE];

   logic [PIPE-1:0]  up_valid;
   logic [WIDTH-1:0] up_data  [PIPE];
   logic [SW-1:0]    up_shamt [PIPE];
   shift_mode_t      up_mode  [PIPE];
   logic             up_sign  [PIPE];
   logic [TAG_W-1:0] up_tag   [PIPE];
   logic [WIDTH-1:0] bank_d   [PIPE];

   logic [WIDTH-1:0] st_in    [SW];
   logic [WIDTH-1:0] st_out   [SW];

   // A bank may move whenever any bank at or downstream of it has a free slot.
   always_comb begin
      adv = '0;
      for (int j = 0; j < PIPE; j++) begin
         adv[j] = out_ready || (|(~valid_q >> j));
      end
   end

   assign in_ready = adv[0];

   for (genvar j = 0; j < PIPE; j++) begin : g_bank
      if (j == 0) begin : g_head
         assign up_valid[0] = in_valid;
         assign up_data[0]  = in_data;
         assign up_shamt[0] = in_shamt;
         assign up_mode[0]  = in_mode;
         assign up_sign[0]  = in_data[WIDTH-1];
         assign up_tag[0]   = in_tag;
      end else begin : g_link
         assign up_valid[j] = valid_q[j-1];
         assign up_data[j]  = data_q[j-1];
         assign up_shamt[j] = shamt_q[j-1];
         assign up_mode[j]  = mode_q[j-1];
         assign up_sign[j]  = sign_q[j-1];
         assign up_tag[j]   = tag_q[j-1];
      end
      if (j * SPB < SW) begin : g_shift
         assign bank_d[j] = st_out[bank_last_stage(j, SPB, SW)];
      end else begin : g_pass
         assign bank_d[j] = up_data[j];
      end
   end

   for (genvar k = 0; k < SW; k++) begin : g_stage
      localparam int B = k / SPB;
      if (k % SPB == 0) begin : g_first
         assign st_in[k] = up_data[B];
      end else begin : g_chain
         assign st_in[k] = st_out[k-1];
      end
      shift_stage #(.WIDTH(WIDTH), .AMT(1 << k)) u_stage (
         .data_i   (st_in[k]),
         .enable_i (up_shamt[B][k]),
         .mode_i   (up_mode[B]),
         .sign_i   (up_sign[B]),
         .data_o   (st_out[k])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         for (int j = 0; j < PIPE; j++) begin
            data_q[j]  <= '0;
            shamt_q[j] <= '0;
            mode_q[j]  <= SH_LSL;
            sign_q[j]  <= 1'b0;
            tag_q[j]   <= '0;
         end
      end else begin
         for (int j = 0; j < PIPE; j++) begin
            if (adv[j]) begin
               valid_q[j] <= up_valid[j];
               // Payload only moves with a real beat so bubbles leave outputs untouched.
               if (up_valid[j]) begin
                  data_q[j]  <= bank_d[j];
                  shamt_q[j] <= up_shamt[j];
                  mode_q[j]  <= up_mode[j];
                  sign_q[j]  <= up_sign[j];
                  tag_q[j]   <= up_tag[j];
               end
            end
         end
      end
   end

   assign out_valid = valid_q[PIPE-1];
   assign out_data  = data_q[PIPE-1];
   assign out_tag   = tag_q[PIPE-1];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb/tb_pipelined_barrel_shifter.sv - directed vectors plus scoreboard model for pipelined_barrel_shifter
module tb_pipelined_barrel_shifter;
   import shifter_pkg::*;

   localparam int WIDTH = 64;
   localparam int PIPE  = 2;
   localparam int TAG_W = 5;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic [5:0]       in_shamt = '0;
   shift_mode_t      in_mode = SH_LSL;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] out_data;
   logic [TAG_W-1:0] out_tag;

   int n_vec = 0;
   int n_err = 0;

   logic [WIDTH-1:0] exp_data_q [$];
   logic [TAG_W-1:0] exp_tag_q  [$];
   logic             have_prev = 1'b0;
   logic [WIDTH-1:0] prev_data;
   logic [TAG_W-1:0] prev_tag;

   pipelined_barrel_shifter #(.WIDTH(WIDTH), .PIPE(PIPE), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_mode   (in_mode),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [63:0] d, input int s, input shift_mode_t m);
      case (m)
         SH_LSL: return d << s;
         SH_ASR: return 64'($signed(d) >>> s);
`ifdef SHIFTER_ROR_EN
         SH_ROR: return (s == 0) ? d : ((d >> s) | (d << (64 - s)));
`endif
         default: return d >> s;
      endcase
   endfunction

   always @(negedge clk) begin
      if (reset) begin
         exp_data_q.delete();
         exp_tag_q.delete();
         have_prev = 1'b0;
      end else begin
         if (have_prev) begin
            check("stall_hold_data", out_data, prev_data);
            check("stall_hold_tag", 64'(out_tag), 64'(prev_tag));
         end
         if (out_valid && out_ready) begin
            if (exp_data_q.size() == 0) begin
               check("spurious_output", 64'(out_valid), 64'd0);
            end else begin
               check("model_data", out_data, exp_data_q.pop_front());
               check("model_tag", 64'(out_tag), 64'(exp_tag_q.pop_front()));
            end
         end
         have_prev = out_valid && !out_ready;
         prev_data = out_data;
         prev_tag  = out_tag;
         if (in_valid && in_ready) begin
            exp_data_q.push_back(model(in_data, int'(in_shamt), in_mode));
            exp_tag_q.push_back(in_tag);
         end
      end
   end

   task automatic send_check(input string name, input logic [63:0] d, input int s,
                             input shift_mode_t m, input logic [4:0] t, input logic [63:0] exp);
      int lat;
      in_data  = d;
      in_shamt = 6'(s);
      in_mode  = m;
      in_tag   = t;
      in_valid = 1'b1;
      @(negedge clk);
      check({name, "_in_ready"}, 64'(in_ready), 64'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1 lat++;
      end
      check({name, "_latency"}, 64'(lat + 1), 64'(PIPE));
      check({name, "_data"}, out_data, exp);
      check({name, "_tag"}, 64'(out_tag), 64'(t));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] got [$];
      logic [63:0] v;
      logic        saw_stall;
      logic        emitted;

      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_out_data", out_data, 64'd0);
      check("reset_out_tag", 64'(out_tag), 64'd0);
      check("reset_in_ready", 64'(in_ready), 64'd1);

      send_check("lsr32", 64'hFFFF_FFFF_FFFF_FFFF, 32, SH_LSR, 5'd7, 64'h0000_0000_FFFF_FFFF);
      send_check("asr4_neg", 64'h8000_0000_0000_0010, 4, SH_ASR, 5'd1, 64'hF800_0000_0000_0001);
      send_check("lsl63", 64'h8000_0000_0000_0010, 63, SH_LSL, 5'd2, 64'h0);
      send_check("asr63_neg", 64'h8000_0000_0000_0010, 63, SH_ASR, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF);
      send_check("asr63_pos", 64'h7FFF_FFFF_FFFF_FFFF, 63, SH_ASR, 5'd4, 64'h0);
      send_check("asr4_pos", 64'h7000_0000_0000_0000, 4, SH_ASR, 5'd5, 64'h0700_0000_0000_0000);
      send_check("lsl4", 64'h0123_4567_89AB_CDEF, 4, SH_LSL, 5'd6, 64'h1234_5678_9ABC_DEF0);
      send_check("lsr8", 64'h8000_0000_0000_00FF, 8, SH_LSR, 5'd8, 64'h0080_0000_0000_0000);
      send_check("lsl0", 64'hDEAD_BEEF_0123_4567, 0, SH_LSL, 5'd9, 64'hDEAD_BEEF_0123_4567);
      send_check("lsr0", 64'hDEAD_BEEF_0123_4567, 0, SH_LSR, 5'd10, 64'hDEAD_BEEF_0123_4567);
      send_check("asr0", 64'hDEAD_BEEF_0123_4567, 0, SH_ASR, 5'd11, 64'hDEAD_BEEF_0123_4567);
      send_check("ror0", 64'hDEAD_BEEF_0123_4567, 0, SH_ROR, 5'd12, 64'hDEAD_BEEF_0123_4567);
`ifdef SHIFTER_ROR_EN
      send_check("ror1", 64'h1, 1, SH_ROR, 5'd13, 64'h8000_0000_0000_0000);
      send_check("ror8", 64'h0000_0000_0000_00AB, 8, SH_ROR, 5'd14, 64'hAB00_0000_0000_0000);
`else
      send_check("ror1_as_lsr", 64'h1, 1, SH_ROR, 5'd13, 64'h0);
      send_check("ror8_as_lsr", 64'h0000_0000_0000_ABCD, 8, SH_ROR, 5'd14, 64'h0000_0000_0000_00AB);
`endif
      @(posedge clk);
      #1;

      saw_stall = 1'b0;
      fork
         begin
            for (int i = 1; i <= 6; i++) begin
               int bound;
               in_data  = 64'(i);
               in_shamt = 6'd1;
               in_mode  = SH_LSL;
               in_tag   = 5'(i);
               in_valid = 1'b1;
               bound = 0;
               @(negedge clk);
               while (!in_ready && bound < 50) begin
                  saw_stall = 1'b1;
                  bound++;
                  @(negedge clk);
               end
               @(posedge clk);
               #1;
            end
            in_valid = 1'b0;
         end
         begin
            for (int c = 1; c <= 20; c++) begin
               out_ready = !(c >= 3 && c <= 6);
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
         begin
            for (int c = 0; c < 30; c++) begin
               @(negedge clk);
               if (out_valid && out_ready) got.push_back(out_data);
            end
         end
      join
      check("bp_in_ready_dropped", 64'(saw_stall), 64'd1);
      check("bp_count", 64'(got.size()), 64'd6);
      for (int i = 0; i < 6; i++) begin
         v = (i < got.size()) ? got[i] : 64'hx;
         check("bp_order", v, 64'(2 * (i + 1)));
      end

      out_ready = 1'b0;
      in_data   = 64'h55;
      in_shamt  = 6'd1;
      in_mode   = SH_LSL;
      in_tag    = 5'd21;
      in_valid  = 1'b1;
      @(posedge clk);
      #1 in_data = 64'h66;
      in_tag = 5'd22;
      @(posedge clk);
      #1 in_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      out_ready = 1'b1;
      check("midreset_out_valid", 64'(out_valid), 64'd0);
      check("midreset_in_ready", 64'(in_ready), 64'd1);
      emitted = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (out_valid) emitted = 1'b1;
      end
      check("midreset_no_emit", 64'(emitted), 64'd0);
      check("scoreboard_drained", 64'(exp_data_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
